hazard_controller: RTL and testbench



---
 rtl/riscv_cpu_pkg.sv | 44 ++++
 rtl/reg_scoreboard.sv | 37 +++
 rtl/hazard_controller.sv | 158 +++++++++++++++
 tb/tb_hazard_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - shared types for the pipeline hazard controller
package riscv_cpu_pkg;

    localparam int ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HAZ_STALL = 2'd1,
        MEM_WAIT  = 2'd2
    } hc_state_e;

    // Youngest producer wins: EX, then MEM, then the register-file write in WB.
    function automatic fwd_sel_e fwd_select(
        input logic                  used,
        input logic [ADDR_WIDTH-1:0] src,
        input logic                  ex_fwd,
        input logic [ADDR_WIDTH-1:0] ex_rd,
        input logic                  mem_fwd,
        input logic [ADDR_WIDTH-1:0] mem_rd,
        input logic                  wb_fwd,
        input logic [ADDR_WIDTH-1:0] wb_rd
    );
        fwd_sel_e sel;
        sel = FWD_NONE;
        if (used && (src != '0)) begin
            if (ex_fwd && (ex_rd == src)) begin
                sel = FWD_EX;
            end else if (mem_fwd && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_fwd && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write bitmap with set-wins update and two read ports
module reg_scoreboard
    import riscv_cpu_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_i,
    input  logic [ADDR_WIDTH-1:0] set_rd_i,
    input  logic                  clr_i,
    input  logic [ADDR_WIDTH-1:0] clr_rd_i,
    input  logic [ADDR_WIDTH-1:0] rs_a_i,
    input  logic [ADDR_WIDTH-1:0] rs_b_i,
    output logic                  pend_a_o,
    output logic                  pend_b_o
);

    logic [NUM_REGS-1:1] r_pending;

    always_ff @(posedge clk_i) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rst_i) begin
                r_pending[i] <= 1'b0;
            end else if (set_i && (set_rd_i == ADDR_WIDTH'(i))) begin
                r_pending[i] <= 1'b1;
            end else if (clr_i && (clr_rd_i == ADDR_WIDTH'(i))) begin
                r_pending[i] <= 1'b0;
            end
        end
    end

    // A register being written back this cycle already reads as clean.
    assign pend_a_o = (rs_a_i != '0) && r_pending[rs_a_i] && !(clr_i && (clr_rd_i == rs_a_i));
    assign pend_b_o = (rs_b_i != '0) && r_pending[rs_b_i] && !(clr_i && (clr_rd_i == rs_b_i));

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RAW hazard, stall/flush/issue and forwarding control; RISCV_CPU_FWD_EN enables bypassing
module hazard_controller
    import riscv_cpu_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [ADDR_WIDTH-1:0] id_rd_i,
    input  logic                  id_we_i,
    input  logic                  id_is_load_i,
    input  logic                  ex_jump_i,
    input  logic                  lsu_busy_i,
    input  logic                  wb_valid_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_rd_i,
    output logic                  issue_o,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  stall_ex_o,
    output logic                  flush_if_o,
    output logic                  flush_id_o,
    output fwd_sel_e              fwd_a_o,
    output fwd_sel_e              fwd_b_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

`ifdef RISCV_CPU_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                  r_ex_v, r_ex_we, r_ex_ld;
    logic [ADDR_WIDTH-1:0] r_ex_rd;
    logic                  r_mem_v, r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_rd;
    hc_state_e             r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    logic     w_wb_wr, w_sb_set;
    logic     w_pend_a, w_pend_b, w_lu_a, w_lu_b, w_haz_a, w_haz_b, w_hazard;
    fwd_sel_e w_fwd_a, w_fwd_b;

    assign w_wb_wr  = wb_valid_i && wb_we_i;
    assign w_sb_set = issue_o && id_we_i && (id_rd_i != '0);

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .set_i    (w_sb_set),
        .set_rd_i (id_rd_i),
        .clr_i    (w_wb_wr),
        .clr_rd_i (wb_rd_i),
        .rs_a_i   (id_rs1_i),
        .rs_b_i   (id_rs2_i),
        .pend_a_o (w_pend_a),
        .pend_b_o (w_pend_b)
    );

    // With bypassing only a load still in EX cannot feed its consumer in time.
    assign w_lu_a   = r_ex_v && r_ex_ld && (r_ex_rd == id_rs1_i);
    assign w_lu_b   = r_ex_v && r_ex_ld && (r_ex_rd == id_rs2_i);
    assign w_haz_a  = id_valid_i && id_rs1_used_i && (id_rs1_i != '0) && (FWD_EN ? w_lu_a : w_pend_a);
    assign w_haz_b  = id_valid_i && id_rs2_used_i && (id_rs2_i != '0) && (FWD_EN ? w_lu_b : w_pend_b);
    assign w_hazard = w_haz_a || w_haz_b;

    assign w_fwd_a = fwd_select(id_rs1_used_i, id_rs1_i,
                                r_ex_v && r_ex_we && !r_ex_ld, r_ex_rd,
                                r_mem_v && r_mem_we, r_mem_rd,
                                w_wb_wr, wb_rd_i);
    assign w_fwd_b = fwd_select(id_rs2_used_i, id_rs2_i,
                                r_ex_v && r_ex_we && !r_ex_ld, r_ex_rd,
                                r_mem_v && r_mem_we, r_mem_rd,
                                w_wb_wr, wb_rd_i);

    assign fwd_a_o = (FWD_EN && !rst_i) ? w_fwd_a : FWD_NONE;
    assign fwd_b_o = (FWD_EN && !rst_i) ? w_fwd_b : FWD_NONE;

    always_comb begin
        w_state_nxt = RUN;
        issue_o     = 1'b0;
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;
        if (rst_i) begin
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
        end else if (lsu_busy_i) begin
            w_state_nxt = MEM_WAIT;
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
        end else if (ex_jump_i) begin
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
        end else if (w_hazard) begin
            w_state_nxt = HAZ_STALL;
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            flush_id_o  = 1'b1;
        end else begin
            issue_o = id_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_v   <= 1'b0;
            r_ex_we  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_ex_rd  <= '0;
            r_mem_v  <= 1'b0;
            r_mem_we <= 1'b0;
            r_mem_rd <= '0;
        end else begin
            if (issue_o) begin
                r_ex_v  <= 1'b1;
                r_ex_we <= id_we_i;
                r_ex_ld <= id_is_load_i;
                r_ex_rd <= id_rd_i;
            end else if (!stall_ex_o) begin
                r_ex_v <= 1'b0;
            end
            if (!stall_ex_o) begin
                r_mem_v  <= r_ex_v;
                r_mem_we <= r_ex_we;
                r_mem_rd <= r_ex_rd;
            end
        end
    end

    // Every non-RUN state was entered through a cycle with stall_id_o high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != RUN) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
module tb_hazard_controller;
    import riscv_cpu_pkg::*;

`ifdef RISCV_CPU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        id_valid_i, id_rs1_used_i, id_rs2_used_i, id_we_i, id_is_load_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, wb_rd_i;
    logic        ex_jump_i, lsu_busy_i, wb_valid_i, wb_we_i;
    logic        issue_o, stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o;
    fwd_sel_e    fwd_a_o, fwd_b_o;
    logic [31:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    hazard_controller #(.NUM_REGS(32), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
        .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_is_load_i(id_is_load_i),
        .ex_jump_i(ex_jump_i), .lsu_busy_i(lsu_busy_i),
        .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
        .issue_o(issue_o), .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
        .stall_ex_o(stall_ex_o), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
        id_rd_i = 0; id_we_i = 0; id_is_load_i = 0;
        ex_jump_i = 0; lsu_busy_i = 0; wb_valid_i = 0; wb_we_i = 0; wb_rd_i = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        id_valid_i = 1; id_rs1_i = rs1; id_rs1_used_i = u1; id_rs2_i = rs2; id_rs2_used_i = u2;
        id_rd_i = rd; id_we_i = we; id_is_load_i = ld;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd);
        wb_valid_i = en; wb_we_i = en; wb_rd_i = rd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        clear_inputs();
        lsu_busy_i = 1;
        set_id(5, 1, 6, 1, 7, 1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, issue_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_stalls: got %b exp 0000", {stall_if_o, stall_id_o, stall_ex_o, issue_o});
        end
        checks++;
        if ({flush_if_o, flush_id_o} !== 2'b11) begin
            errors++; $display("FAIL reset_flush: got %b exp 11", {flush_if_o, flush_id_o});
        end
        checks++;
        if (stall_cnt_o !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d exp 0", stall_cnt_o);
        end
        checks++;
        if ({fwd_a_o, fwd_b_o} !== {FWD_NONE, FWD_NONE}) begin
            errors++; $display("FAIL reset_fwd: got %0d/%0d exp 0/0", fwd_a_o, fwd_b_o);
        end
        next_cycle();
        rst_i = 0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut.r_state !== RUN) begin
            errors++; $display("FAIL reset_state: got %0d exp %0d", dut.r_state, RUN);
        end
        next_cycle();
    endtask

    // addi x3,x1,imm then sub x4,x3,x3; x3 is written back three cycles after issue
    task automatic test_raw_alu();
        int n_stall;
        bit issued;
        n_stall = 0;
        issued  = 0;
        do_reset();
        set_id(1, 1, 0, 0, 3, 1, 0);
        @(negedge clk);
        checks++;
        if (issue_o !== 1'b1) begin
            errors++; $display("FAIL raw_producer_issue: got %b exp 1", issue_o);
        end
        next_cycle();
        set_id(3, 1, 3, 1, 4, 1, 0);
        for (int c = 1; c < 10 && !issued; c++) begin
            set_wb(c == 3, 3);
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, issue_o} !== (FWD ? 6'b000001 : 6'b110010)) begin
                    errors++; $display("FAIL raw_first_ctrl: got %b exp %b",
                        {stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, issue_o}, FWD ? 6'b000001 : 6'b110010);
                end
                checks++;
                if ({fwd_a_o, fwd_b_o} !== (FWD ? {FWD_EX, FWD_EX} : {FWD_NONE, FWD_NONE})) begin
                    errors++; $display("FAIL raw_fwd: got %0d/%0d exp %0d", fwd_a_o, fwd_b_o, FWD ? FWD_EX : FWD_NONE);
                end
            end
            if (stall_id_o) n_stall++;
            if (issue_o) issued = 1;
            next_cycle();
        end
        clear_inputs();
        checks++;
        if (!issued) begin
            errors++; $display("FAIL raw_issue_timeout: got 0 exp 1");
        end
        checks++;
        if (n_stall != (FWD ? 0 : 2)) begin
            errors++; $display("FAIL raw_stalls: got %0d exp %0d", n_stall, FWD ? 0 : 2);
        end
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if (stall_cnt_o !== (FWD ? 32'd0 : 32'd2)) begin
            errors++; $display("FAIL raw_cnt: got %0d exp %0d", stall_cnt_o, FWD ? 0 : 2);
        end
        next_cycle();
    endtask

    // lw x5 then add x6,x5,x1
    task automatic test_load_use();
        int n_stall, iss_cyc;
        fwd_sel_e fa, fb;
        n_stall = 0;
        iss_cyc = -1;
        fa = FWD_WB;
        fb = FWD_WB;
        do_reset();
        set_id(2, 1, 0, 0, 5, 1, 1);
        next_cycle();
        set_id(5, 1, 1, 1, 6, 1, 0);
        for (int c = 1; c < 10 && iss_cyc < 0; c++) begin
            set_wb(c == 3, 5);
            @(negedge clk);
            if (stall_id_o) n_stall++;
            if (issue_o) begin
                iss_cyc = c; fa = fwd_a_o; fb = fwd_b_o;
            end
            next_cycle();
        end
        clear_inputs();
        checks++;
        if (iss_cyc != (FWD ? 2 : 3)) begin
            errors++; $display("FAIL lu_issue_cycle: got %0d exp %0d", iss_cyc, FWD ? 2 : 3);
        end
        checks++;
        if (n_stall != (FWD ? 1 : 2)) begin
            errors++; $display("FAIL lu_stalls: got %0d exp %0d", n_stall, FWD ? 1 : 2);
        end
        checks++;
        if (fa !== (FWD ? FWD_MEM : FWD_NONE)) begin
            errors++; $display("FAIL lu_fwd_a: got %0d exp %0d", fa, FWD ? FWD_MEM : FWD_NONE);
        end
        checks++;
        if (fb !== FWD_NONE) begin
            errors++; $display("FAIL lu_fwd_b: got %0d exp %0d", fb, FWD_NONE);
        end
    endtask

    task automatic test_jump();
        do_reset();
        set_id(0, 0, 0, 0, 7, 1, 1);
        next_cycle();
        set_id(7, 1, 0, 0, 9, 1, 0);
        ex_jump_i = 1;
        @(negedge clk);
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, issue_o} !== 6'b000110) begin
            errors++; $display("FAIL jump_ctrl: got %b exp 000110",
                {stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, issue_o});
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut.r_state !== RUN) begin
            errors++; $display("FAIL jump_state: got %0d exp %0d", dut.r_state, RUN);
        end
        checks++;
        if (dut.u_scoreboard.r_pending[7] !== 1'b1) begin
            errors++; $display("FAIL jump_pend7: got %b exp 1", dut.u_scoreboard.r_pending[7]);
        end
        checks++;
        if (dut.u_scoreboard.r_pending[9] !== 1'b0) begin
            errors++; $display("FAIL jump_pend9: got %b exp 0", dut.u_scoreboard.r_pending[9]);
        end
        next_cycle();
    endtask

    // lw x5, then add x6,x5 arrives while the LSU is busy for 4 cycles
    task automatic test_mem_wait();
        int n_stall, iss_cyc;
        fwd_sel_e fa;
        n_stall = 0;
        iss_cyc = -1;
        fa = FWD_WB;
        do_reset();
        set_id(0, 0, 0, 0, 5, 1, 1);
        next_cycle();
        set_id(5, 1, 0, 0, 6, 1, 0);
        lsu_busy_i = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if ({stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, issue_o} !== 6'b111000) begin
                errors++; $display("FAIL memwait_ctrl_c%0d: got %b exp 111000", c,
                    {stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, issue_o});
            end
            if (c > 1) begin
                checks++;
                if (dut.r_state !== MEM_WAIT) begin
                    errors++; $display("FAIL memwait_state_c%0d: got %0d exp %0d", c, dut.r_state, MEM_WAIT);
                end
            end
            next_cycle();
        end
        lsu_busy_i = 0;
        for (int c = 5; c < 15 && iss_cyc < 0; c++) begin
            set_wb(c == 7, 5);
            @(negedge clk);
            if (stall_id_o) n_stall++;
            if (issue_o) begin
                iss_cyc = c; fa = fwd_a_o;
            end
            next_cycle();
        end
        clear_inputs();
        checks++;
        if (iss_cyc != (FWD ? 6 : 7)) begin
            errors++; $display("FAIL memwait_issue_cycle: got %0d exp %0d", iss_cyc, FWD ? 6 : 7);
        end
        checks++;
        if (n_stall != (FWD ? 1 : 2)) begin
            errors++; $display("FAIL memwait_haz_stalls: got %0d exp %0d", n_stall, FWD ? 1 : 2);
        end
        checks++;
        if (fa !== (FWD ? FWD_MEM : FWD_NONE)) begin
            errors++; $display("FAIL memwait_fwd: got %0d exp %0d", fa, FWD ? FWD_MEM : FWD_NONE);
        end
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if (stall_cnt_o !== (FWD ? 32'd5 : 32'd6)) begin
            errors++; $display("FAIL memwait_cnt: got %0d exp %0d", stall_cnt_o, FWD ? 5 : 6);
        end
        next_cycle();
    endtask

    task automatic test_x0();
        do_reset();
        set_id(0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        checks++;
        if (issue_o !== 1'b1) begin
            errors++; $display("FAIL x0_producer_issue: got %b exp 1", issue_o);
        end
        next_cycle();
        set_id(0, 1, 0, 1, 0, 1, 0);
        set_wb(1, 0);
        @(negedge clk);
        checks++;
        if ({stall_id_o, issue_o} !== 2'b01) begin
            errors++; $display("FAIL x0_consumer: got %b exp 01", {stall_id_o, issue_o});
        end
        checks++;
        if ({fwd_a_o, fwd_b_o} !== {FWD_NONE, FWD_NONE}) begin
            errors++; $display("FAIL x0_fwd: got %0d/%0d exp 0/0", fwd_a_o, fwd_b_o);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut.u_scoreboard.r_pending !== '0) begin
            errors++; $display("FAIL x0_pending: got %h exp 0", dut.u_scoreboard.r_pending);
        end
        next_cycle();
    endtask

    // x8 written back in the same cycle it is read and re-targeted
    task automatic test_wb_same_cycle();
        do_reset();
        set_id(0, 0, 0, 0, 8, 1, 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({stall_id_o, issue_o} !== 2'b00) begin
            errors++; $display("FAIL wb_bubble: got %b exp 00", {stall_id_o, issue_o});
        end
        next_cycle();
        set_id(8, 1, 8, 1, 8, 1, 0);
        set_wb(1, 8);
        @(negedge clk);
        checks++;
        if ({stall_id_o, issue_o} !== 2'b01) begin
            errors++; $display("FAIL wb_same_cycle: got %b exp 01", {stall_id_o, issue_o});
        end
        checks++;
        if (fwd_a_o !== (FWD ? FWD_MEM : FWD_NONE)) begin
            errors++; $display("FAIL wb_fwd_a: got %0d exp %0d", fwd_a_o, FWD ? FWD_MEM : FWD_NONE);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut.u_scoreboard.r_pending[8] !== 1'b1) begin
            errors++; $display("FAIL wb_set_wins: got %b exp 1", dut.u_scoreboard.r_pending[8]);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(0, 0, 0, 0, 5, 1, 1);
        next_cycle();
        set_id(5, 1, 0, 0, 6, 1, 0);
        @(negedge clk);
        checks++;
        if (stall_id_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_stall: got %b exp 1", stall_id_o);
        end
        next_cycle();
        rst_i = 1;
        @(negedge clk);
        checks++;
        if ({stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, issue_o} !== 6'b000110) begin
            errors++; $display("FAIL rstmid_ctrl: got %b exp 000110",
                {stall_if_o, stall_id_o, stall_ex_o, flush_if_o, flush_id_o, issue_o});
        end
        next_cycle();
        rst_i = 0;
        @(negedge clk);
        checks++;
        if (dut.r_state !== RUN) begin
            errors++; $display("FAIL rstmid_state: got %0d exp %0d", dut.r_state, RUN);
        end
        checks++;
        if ({stall_id_o, issue_o} !== 2'b01) begin
            errors++; $display("FAIL rstmid_issue: got %b exp 01", {stall_id_o, issue_o});
        end
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        rst_i = 1;
        clear_inputs();
        test_reset();
        test_raw_alu();
        test_load_use();
        test_jump();
        test_mem_wait();
        test_x0();
        test_wb_same_cycle();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
